// File: rtl/fwd_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : fwd_hazard_scoreboard
// Description : Shift-register scoreboard of in-flight destinations that
//               produces EX forward selects, ID branch-operand selects and a
//               load-use / branch-in-ID stall. Optional macro
//               FWD_STALL_CNT_EN adds a saturating stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_hazard_scoreboard #(
    parameter int AW     = 5,
    parameter int STAGES = 3,   // legal range 2..7
    parameter int SEL_W  = 2    // 2**SEL_W >= STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_rs,
    input  logic [AW-1:0]    id_rt,
    input  logic             id_use_rt,
    input  logic             id_branch,
    input  logic             id_wr,
    input  logic [AW-1:0]    id_rd,
    input  logic             id_load,
    input  logic             flush,
    output logic             stall,
    output logic [SEL_W-1:0] ex_fwd_a,
    output logic [SEL_W-1:0] ex_fwd_b,
    output logic [SEL_W-1:0] id_fwd_a,
    output logic [SEL_W-1:0] id_fwd_b
`ifdef FWD_STALL_CNT_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    logic [STAGES-1:0] r_v;
    logic [STAGES-1:0] r_ld;
    logic [AW-1:0]     r_rd [STAGES];

    logic [STAGES-1:0] w_m_rs;
    logic [STAGES-1:0] w_m_rt;
    logic              w_any0;
    logic              w_any1;
    logic              w_stall;
    logic              w_slot0_v;
    logic [SEL_W-1:0]  w_ex_a;
    logic [SEL_W-1:0]  w_ex_b;
    logic [SEL_W-1:0]  w_id_a;
    logic [SEL_W-1:0]  w_id_b;
    logic [SEL_W-1:0]  r_ex_a;
    logic [SEL_W-1:0]  r_ex_b;

    generate
        for (genvar j = 0; j < STAGES; j++) begin : g_match
            assign w_m_rs[j] = r_v[j] && (r_rd[j] != '0) && (r_rd[j] == id_rs);
            assign w_m_rt[j] = r_v[j] && (r_rd[j] != '0) && (r_rd[j] == id_rt) && id_use_rt;
        end
    endgenerate

    assign w_any0 = w_m_rs[0] | w_m_rt[0];
    assign w_any1 = w_m_rs[1] | w_m_rt[1];

    always_comb begin
        w_stall = 1'b0;
        if (id_valid && !flush) begin
            w_stall = (w_any0 && r_ld[0])
                    || (id_branch && w_any0)
                    || (id_branch && w_any1 && r_ld[1]);
        end
    end

    assign stall     = w_stall;
    assign w_slot0_v = id_valid && id_wr && !w_stall && !flush;

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        w_ex_a = '0;
        w_ex_b = '0;
        for (int j = STAGES - 2; j >= 0; j--) begin
            if (w_m_rs[j]) w_ex_a = SEL_W'(j + 1);
            if (w_m_rt[j]) w_ex_b = SEL_W'(j + 1);
        end
        if (w_stall || flush || !id_valid) begin
            w_ex_a = '0;
            w_ex_b = '0;
        end
    end

    // A load in slot 1 has no data yet; the branch stall covers that case.
    always_comb begin
        w_id_a = '0;
        w_id_b = '0;
        if (id_branch) begin
            for (int j = STAGES - 2; j >= 1; j--) begin
                if (w_m_rs[j] && !r_ld[j]) w_id_a = SEL_W'(j);
                if (w_m_rt[j] && !r_ld[j]) w_id_b = SEL_W'(j);
            end
        end
    end

    assign id_fwd_a = w_id_a;
    assign id_fwd_b = w_id_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v  <= '0;
            r_ld <= '0;
            for (int j = 0; j < STAGES; j++) r_rd[j] <= '0;
        end else begin
            r_v  <= {r_v[STAGES-2:0], w_slot0_v};
            r_ld <= {r_ld[STAGES-2:0], id_load};
            r_rd[0] <= id_rd;
            for (int j = 1; j < STAGES; j++) r_rd[j] <= r_rd[j-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_a <= '0;
            r_ex_b <= '0;
        end else begin
            r_ex_a <= w_ex_a;
            r_ex_b <= w_ex_b;
        end
    end

    assign ex_fwd_a = r_ex_a;
    assign ex_fwd_b = r_ex_b;

`ifdef FWD_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_fwd_hazard_scoreboard
// Description : Directed + random bench for fwd_hazard_scoreboard, STAGES=3
//               and STAGES=4 instances driven in parallel against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_scoreboard;

    logic       clk;
    logic       rst;
    logic       id_valid, id_use_rt, id_branch, id_wr, id_load, flush;
    logic [4:0] id_rs, id_rt, id_rd;

    logic       s3_stall, s4_stall;
    logic [1:0] s3_exa, s3_exb, s3_ida, s3_idb;
    logic [1:0] s4_exa, s4_exb, s4_ida, s4_idb;
`ifdef FWD_STALL_CNT_EN
    logic [31:0] s3_cnt, s4_cnt;
`endif

    int errors = 0;
    int checks = 0;

    fwd_hazard_scoreboard #(.AW(5), .STAGES(3), .SEL_W(2)) u_dut3 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rt(id_use_rt), .id_branch(id_branch), .id_wr(id_wr), .id_rd(id_rd),
        .id_load(id_load), .flush(flush), .stall(s3_stall),
        .ex_fwd_a(s3_exa), .ex_fwd_b(s3_exb), .id_fwd_a(s3_ida), .id_fwd_b(s3_idb)
`ifdef FWD_STALL_CNT_EN
        , .stall_cnt(s3_cnt)
`endif
    );

    fwd_hazard_scoreboard #(.AW(5), .STAGES(4), .SEL_W(2)) u_dut4 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rt(id_use_rt), .id_branch(id_branch), .id_wr(id_wr), .id_rd(id_rd),
        .id_load(id_load), .flush(flush), .stall(s4_stall),
        .ex_fwd_a(s4_exa), .ex_fwd_b(s4_exb), .id_fwd_a(s4_ida), .id_fwd_b(s4_idb)
`ifdef FWD_STALL_CNT_EN
        , .stall_cnt(s4_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model: history of what issued into EX each cycle, youngest at 0.
    typedef struct { logic v; logic [4:0] rd; logic ld; } ent_t;
    ent_t hist [8];
    int   m_ex_a3, m_ex_b3, m_ex_a4, m_ex_b4;
    int   m_cnt;
    logic obs_stall;
    logic [1:0] obs_ida3, obs_idb3, obs_ida4;

    function automatic logic hit(int j, logic [4:0] src, logic use_src);
        return hist[j].v && (hist[j].rd != 5'd0) && (hist[j].rd == src) && use_src;
    endfunction

    // Youngest producer among EX-forwardable slots; data then sits in latch j+1.
    function automatic int ex_sel(int s, logic [4:0] src, logic use_src);
        for (int j = 0; j <= s - 2; j++) if (hit(j, src, use_src)) return j + 1;
        return 0;
    endfunction

    function automatic int id_sel(int s, logic [4:0] src, logic use_src);
        for (int j = 1; j <= s - 2; j++) if (hit(j, src, use_src) && !hist[j].ld) return j;
        return 0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic br, input logic wr,
                       input logic [4:0] rd, input logic ld, input logic fl,
                       input logic r);
        logic any0, any1, ms;
        int   ea3, eb3, ea4, eb4;
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rt = urt; id_branch = br;
        id_wr = wr; id_rd = rd; id_load = ld; flush = fl; rst = r;
        #1;
        any0 = hit(0, rs, 1'b1) || hit(0, rt, urt);
        any1 = hit(1, rs, 1'b1) || hit(1, rt, urt);
        ms   = v && !fl && ((any0 && hist[0].ld) || (br && any0) || (br && any1 && hist[1].ld));
        obs_stall = s3_stall;
        obs_ida3  = s3_ida;
        obs_idb3  = s3_idb;
        obs_ida4  = s4_ida;
        if (!r) begin
            chk("stall_s3", {31'd0, s3_stall}, {31'd0, ms});
            chk("stall_s4", {31'd0, s4_stall}, {31'd0, ms});
            if (!ms) begin
                chk("id_fwd_a_s3", {30'd0, s3_ida}, br ? id_sel(3, rs, 1'b1) : 0);
                chk("id_fwd_b_s3", {30'd0, s3_idb}, br ? id_sel(3, rt, urt) : 0);
                chk("id_fwd_a_s4", {30'd0, s4_ida}, br ? id_sel(4, rs, 1'b1) : 0);
                chk("id_fwd_b_s4", {30'd0, s4_idb}, br ? id_sel(4, rt, urt) : 0);
            end
        end
        ea3 = ex_sel(3, rs, 1'b1); eb3 = ex_sel(3, rt, urt);
        ea4 = ex_sel(4, rs, 1'b1); eb4 = ex_sel(4, rt, urt);
        if (ms || fl || !v || r) begin ea3 = 0; eb3 = 0; ea4 = 0; eb4 = 0; end
        @(posedge clk);
        if (r) begin
            for (int j = 0; j < 8; j++) hist[j] = '{1'b0, 5'd0, 1'b0};
            m_cnt = 0;
        end else begin
            for (int j = 7; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = '{v && wr && !ms && !fl, rd, ld};
            if (ms) m_cnt++;
        end
        m_ex_a3 = ea3; m_ex_b3 = eb3; m_ex_a4 = ea4; m_ex_b4 = eb4;
        #1;
        chk("ex_fwd_a_s3", {30'd0, s3_exa}, m_ex_a3);
        chk("ex_fwd_b_s3", {30'd0, s3_exb}, m_ex_b3);
        chk("ex_fwd_a_s4", {30'd0, s4_exa}, m_ex_a4);
        chk("ex_fwd_b_s4", {30'd0, s4_exb}, m_ex_b4);
`ifdef FWD_STALL_CNT_EN
        chk("stall_cnt_s3", s3_cnt, m_cnt);
        chk("stall_cnt_s4", s4_cnt, m_cnt);
`endif
    endtask

    task automatic idle();
        cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int j = 0; j < 8; j++) hist[j] = '{1'b0, 5'd0, 1'b0};
        m_cnt = 0;
        id_valid = 0; id_rs = 0; id_rt = 0; id_use_rt = 0; id_branch = 0;
        id_wr = 0; id_rd = 0; id_load = 0; flush = 0; rst = 1;
        @(posedge clk); #1;
        cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        idle();
        chk("reset_exa", {30'd0, s3_exa}, 0);
        chk("reset_stall", {31'd0, obs_stall}, 0);

        // add $3 ; sub $4,$3,$5
        cyc(1, 5'd1, 5'd2, 1, 0, 1, 5'd3, 0, 0, 0);
        cyc(1, 5'd3, 5'd5, 1, 0, 1, 5'd4, 0, 0, 0);
        chk("tp1_stall", {31'd0, obs_stall}, 0);
        chk("tp1_exa", {30'd0, s3_exa}, 1);
        chk("tp1_exb", {30'd0, s3_exb}, 0);
        idle(); idle(); idle();

        // lw $2 ; or $6,$2,$2 (stall once, then forward from MEM/WB)
        cyc(1, 5'd1, 5'd0, 0, 0, 1, 5'd2, 1, 0, 0);
        cyc(1, 5'd2, 5'd2, 1, 0, 1, 5'd6, 0, 0, 0);
        chk("tp2_stall", {31'd0, obs_stall}, 1);
        chk("tp2_bubble_exa", {30'd0, s3_exa}, 0);
        cyc(1, 5'd2, 5'd2, 1, 0, 1, 5'd6, 0, 0, 0);
        chk("tp2_issue", {31'd0, obs_stall}, 0);
        chk("tp2_exa", {30'd0, s3_exa}, 2);
        chk("tp2_exb", {30'd0, s3_exb}, 2);
        idle(); idle(); idle();

        // add $7 ; beq $7,$0
        cyc(1, 5'd1, 5'd2, 1, 0, 1, 5'd7, 0, 0, 0);
        cyc(1, 5'd7, 5'd0, 1, 1, 0, 5'd0, 0, 0, 0);
        chk("tp3_stall", {31'd0, obs_stall}, 1);
        cyc(1, 5'd7, 5'd0, 1, 1, 0, 5'd0, 0, 0, 0);
        chk("tp3_go", {31'd0, obs_stall}, 0);
        chk("tp3_ida", {30'd0, obs_ida3}, 1);
        chk("tp3_idb", {30'd0, obs_idb3}, 0);
        idle(); idle(); idle();

        // lw $7 ; beq $7,$0 (two stalls, then register file)
        cyc(1, 5'd1, 5'd0, 0, 0, 1, 5'd7, 1, 0, 0);
        cyc(1, 5'd7, 5'd0, 1, 1, 0, 5'd0, 0, 0, 0);
        chk("tp3l_stall1", {31'd0, obs_stall}, 1);
        cyc(1, 5'd7, 5'd0, 1, 1, 0, 5'd0, 0, 0, 0);
        chk("tp3l_stall2", {31'd0, obs_stall}, 1);
        cyc(1, 5'd7, 5'd0, 1, 1, 0, 5'd0, 0, 0, 0);
        chk("tp3l_go", {31'd0, obs_stall}, 0);
        chk("tp3l_ida", {30'd0, obs_ida3}, 0);
        idle(); idle(); idle();

        // $0 producer/consumer ; two producers of $9 then consumer
        cyc(1, 5'd1, 5'd2, 1, 0, 1, 5'd0, 1, 0, 0);
        cyc(1, 5'd0, 5'd0, 1, 1, 1, 5'd4, 0, 0, 0);
        chk("tp4_r0_stall", {31'd0, obs_stall}, 0);
        chk("tp4_r0_exa", {30'd0, s3_exa}, 0);
        cyc(1, 5'd1, 5'd2, 1, 0, 1, 5'd9, 0, 0, 0);
        cyc(1, 5'd1, 5'd2, 1, 0, 1, 5'd9, 0, 0, 0);
        cyc(1, 5'd9, 5'd3, 1, 0, 1, 5'd10, 0, 0, 0);
        chk("tp4_youngest", {30'd0, s3_exa}, 1);
        idle(); idle(); idle();

        // flush during load-use ; reset with entries in flight
        cyc(1, 5'd1, 5'd0, 0, 0, 1, 5'd8, 1, 0, 0);
        cyc(1, 5'd8, 5'd0, 0, 0, 1, 5'd11, 0, 1, 0);
        chk("tp5_flush_stall", {31'd0, obs_stall}, 0);
        chk("tp5_flush_exa", {30'd0, s3_exa}, 0);
        cyc(1, 5'd11, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0);
        chk("tp5_flush_bubble", {30'd0, s3_exa}, 0);
        cyc(1, 5'd1, 5'd0, 0, 0, 1, 5'd12, 0, 0, 0);
        cyc(1, 5'd1, 5'd0, 0, 0, 1, 5'd13, 1, 0, 0);
        cyc(1, 5'd1, 5'd0, 0, 0, 1, 5'd14, 0, 0, 0);
        cyc(1, 5'd13, 5'd14, 1, 1, 0, 5'd0, 0, 0, 1);
        cyc(1, 5'd13, 5'd14, 1, 1, 0, 5'd0, 0, 0, 0);
        chk("tp5_rst_stall", {31'd0, obs_stall}, 0);
        chk("tp5_rst_ida", {30'd0, obs_ida3}, 0);
        chk("tp5_rst_exa", {30'd0, s3_exa}, 0);
        idle(); idle(); idle();

        // producer $5, two unrelated, consumer: depth 4 forwards from latch 3
        cyc(1, 5'd1, 5'd2, 1, 0, 1, 5'd5, 0, 0, 0);
        cyc(1, 5'd1, 5'd2, 1, 0, 1, 5'd20, 0, 0, 0);
        cyc(1, 5'd1, 5'd2, 1, 0, 1, 5'd21, 0, 0, 0);
        cyc(1, 5'd5, 5'd2, 1, 0, 1, 5'd22, 0, 0, 0);
        chk("tp6_s4_exa", {30'd0, s4_exa}, 3);
        chk("tp6_s3_exa", {30'd0, s3_exa}, 0);

        for (int n = 0; n < 600; n++) begin
            cyc($urandom_range(0, 7) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                1'($urandom), $urandom_range(0, 3) == 0, 1'($urandom),
                5'($urandom_range(0, 7)), $urandom_range(0, 2) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fwd_hazard_scoreboard.md
Name: fwd_hazard_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the pipelined core; successor to the combinational forwarding unit.
- Keeps a shift-register scoreboard of in-flight destination registers over STAGES post-ID slots.
- Computes, at ID time, registered EX forward selects, combinational ID-stage branch-operand selects, and a pipeline stall.
- Adds load-use and branch-in-ID stall detection, flush and a configurable pipeline depth, none of which the previous unit had.

Parameters:
- AW, 5: register-address width.
- STAGES, 3: in-flight slots after ID (slot 0 = EX, slot 1 = MEM, ..., slot STAGES-1 = WB). Legal range 2..7.
- SEL_W, 2: forward-select width. Must satisfy 2**SEL_W >= STAGES.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  AW  ID source A.
- id_rt  in  AW  ID source B.
- id_use_rt  in  1  ID instruction reads rt.
- id_branch  in  1  ID instruction resolves a branch in ID.
- id_wr  in  1  ID instruction writes a register.
- id_rd  in  AW  ID destination.
- id_load  in  1  ID instruction is a load.
- flush  in  1  squash the ID instruction (taken branch / jump).
- stall  out  1  hold PC and IF/ID; insert a bubble into EX.
- ex_fwd_a  out  SEL_W  registered EX operand A select: 0 = ID/EX register value; k = stage latch k (1 = EX/MEM, 2 = MEM/WB, ...).
- ex_fwd_b  out  SEL_W  same for operand B.
- id_fwd_a  out  SEL_W  combinational branch comparator A select, same encoding.
- id_fwd_b  out  SEL_W  same for comparator B.

Behaviour:
- Slot entry: {v, rd, ld}. An entry only matches a source when v=1, rd≠0 and rd equals that source. For rt, id_use_rt=1 is also required.
- Each cycle all slots shift: slot j+1 <= slot j, and the oldest slot is dropped.
- Slot 0 loads {id_valid & id_wr, id_rd, id_load} when stall=0 and flush=0. Otherwise slot 0 loads v=0 (bubble).
- Stall, combinational, asserted only when id_valid=1:
  - Load-use: slot 0 matches rs or rt with ld=1.
  - Branch: id_branch=1 and slot 0 matches a source, any ld.
  - Branch: id_branch=1 and slot 1 matches a source with ld=1.
- flush forces stall=0.
- ex_fwd_x, registered:
  - Computed from the youngest match among slots 0..STAGES-2; select value = matching slot index + 1.
  - No match gives 0, because slot STAGES-1 writes the register file this cycle and the register file is write-through.
  - Cleared to 0 when stall=1, flush=1 or id_valid=0, since a bubble enters EX.
  - Becomes valid on the cycle the instruction is in EX (1-cycle latency).
- id_fwd_x, combinational:
  - Youngest non-load match among slots 1..STAGES-2 gives that slot index.
  - 0 otherwise, or when id_branch=0.
  - Don't-care while stall=1.
- Priority: the youngest slot always wins on multiple matches.
- Register 0 never forwards and never stalls.
- Reset: all slots v=0; ex_fwd_a = ex_fwd_b = 0. This makes stall=0 and id_fwd=0 in the cycle after reset.
- Reset mid-operation discards all in-flight entries.
- A load's data is never selected from slot 1 (EX/MEM). The stall guarantees the consumer sees the load in slot ≥2.

Optional Feature:
- Macro: FWD_STALL_CNT_EN.
- When defined, adds output stall_cnt [31:0]:
  - Counts cycles with stall=1.
  - Saturates at 32'hFFFFFFFF.
  - Cleared by rst.
- When undefined, the port and counter do not exist; all other behaviour is identical.

Test Plan:
1. Sequence `add $3,..` then `sub $4,$3,$5` (no stall) → stall=0; next cycle ex_fwd_a=1, ex_fwd_b=0.
2. `lw $2` then `or $6,$2,$2` → one stall cycle with bubble; next issue gives ex_fwd_a=ex_fwd_b=2; with FWD_STALL_CNT_EN, stall_cnt=1.
3. `add $7` then `beq $7,$0` → stall 1 cycle; then id_fwd_a=1, id_fwd_b=0. Repeat with `lw $7` → 2 stall cycles, then id_fwd_a=0 (register file).
4. Destination $0 in a producer followed by a consumer of $0 → stall=0 and all selects 0. Two producers of $9 back-to-back, then a consumer → ex_fwd_a=1 (youngest).
5. Asserting flush during a load-use condition → stall=0, slot 0 bubble, ex_fwd=0. Asserting rst with 3 entries in flight → next cycle stall=0 and all forward selects 0.
6. STAGES=4, SEL_W=2: producer of $5 followed by 2 unrelated instructions, then a consumer → ex_fwd_a=3.
